currctrl_debug_capture_ctrl: RTL and testbench
==============================================

# currctrl_debug_capture_ctrl

Capture sequencer for the current-control debug RAM. Takes one 32-bit sample stream from the current-control loop and writes it into port 2 of the 512 x 32 dual-port debug RAM as a circular pre/post-trigger buffer. Port 1 of that RAM stays with the Avalon host for readout. The block tracks the trigger position and reports capture status to the host-side CSR block.

## Interface
Parameters:
- ADDR_W, 9, RAM address width; depth is 2^ADDR_W words.
- DATA_W, 32, sample and RAM word width.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle start-capture pulse.
- abort  in  1  single-cycle cancel pulse.
- pretrig_len  in  ADDR_W  number of samples kept before the trigger; latched on arm.
- sample_valid  in  1  a sample is present this cycle.
- sample_data  in  DATA_W  sample value.
- trig_in  in  1  trigger qualifier; only sampled when sample_valid=1.
- ram_address  out  ADDR_W  RAM port-2 address.
- ram_writedata  out  DATA_W  RAM port-2 write data.
- ram_byteenable  out  4  constant 4'hF.
- ram_chipselect  out  1  asserted together with ram_write.
- ram_write  out  1  RAM port-2 write strobe.
- ram_clken  out  1  constant 1.
- busy  out  1  a capture is in progress (state PRE, ARMED or POST).
- done  out  1  capture complete; held until the next arm or abort.
- trig_addr  out  ADDR_W  RAM address of the trigger sample.
- start_addr  out  ADDR_W  address of the oldest valid sample, equal to trig_addr - pretrig_len mod 2^ADDR_W.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE or DONE, on arm:
  - wr_ptr<=0; pretrig_len is latched to plen.
  - Go to PRE, or straight to ARMED if plen=0.
  - done<=0.
- PRE:
  - Each sample_valid writes at wr_ptr, then wr_ptr++ and cnt++.
  - When cnt reaches plen, go to ARMED.
  - trig_in is ignored in this state.
- ARMED:
  - Writes continue circularly; wr_ptr wraps from 2^ADDR_W-1 to 0.
  - On sample_valid with the trigger qualified:
    - That sample is written.
    - trig_addr<=wr_ptr.
    - post<=2^ADDR_W-1-plen.
    - Go to POST, or to DONE if post=0.
- POST:
  - Each sample_valid writes the sample and decrements post.
  - After the write that brings post to 0, go to DONE.
- DONE: done=1, busy=0, no writes. start_addr is valid.
- abort in any state: go to IDLE next cycle and clear done. No write is issued for the sample accepted in the abort cycle.
- arm while busy is ignored. If arm and abort arrive in the same cycle, abort wins.
- Address arithmetic is modulo 2^ADDR_W. Counters are ADDR_W+1 bits wide, so there is no overflow at plen = 2^ADDR_W-1.
- A capture always fills exactly 2^ADDR_W words: plen pre-trigger samples, the trigger sample, and 2^ADDR_W-1-plen post-trigger samples.

## Timing
- Reset values:
  - State IDLE.
  - ram_address=0, ram_writedata=0, ram_write=0, ram_chipselect=0.
  - busy=0, done=0, trig_addr=0, start_addr=0.
  - ram_byteenable=4'hF and ram_clken=1 at all times.
- RAM port outputs are registered. A sample accepted in cycle N gives ram_write/ram_address/ram_writedata in cycle N+1, exactly one cycle wide per sample.
- Back-to-back sample_valid sustains one write per cycle.
- busy rises the cycle after arm.
- The final write and the DONE transition happen in the same cycle, so done=1 in cycle N+1, the cycle of the final ram_write.
- trig_addr and start_addr update in the cycle after the trigger sample is accepted. start_addr is only meaningful while done=1.
- An asynchronous reset mid-capture returns to IDLE immediately, with no further writes.

## Configuration
- CURRCTRL_DBG_TRIG_EDGE_EN defined:
  - The trigger qualifies on a rising edge of trig_in, evaluated across consecutive sample_valid cycles.
  - The previous trig_in value is held in a register that resets to 1 and reloads on arm. A trigger already high at arm therefore does not fire.
- Not defined: the trigger qualifies whenever trig_in=1 with sample_valid=1 (level sensitive).

## Test plan
- pretrig_len=0, trig_in held high, 512 continuous samples of value = index → exactly 512 writes to addresses 0..511 with data 0..511; trig_addr=0, start_addr=0, done=1 in the cycle of the final write.
- pretrig_len=100, trigger on sample 700 (counting from 0) → trig_addr=700 mod 512=188, start_addr=88, 411 post writes; the last write lands at address 87.
- pretrig_len=511, trigger on the first sample after ARMED → no POST writes; DONE the cycle after the trigger write; trig_addr=511, start_addr=0.
- abort in cycle 40 of ARMED, then arm → busy drops, done=0, no write after the abort cycle; the new capture restarts at address 0.
- arm pulsed during POST, and arm+abort in the same cycle → arm ignored in the first case; IDLE in the second.
- With CURRCTRL_DBG_TRIG_EDGE_EN defined, trig_in high from arm, low at sample 5, high at sample 9 → trig_addr corresponds to sample 9. Without the macro, trig_addr is the first sample after ARMED.

Source files
------------

// File: rtl/currctrl_debug_capture_ctrl.sv
// Circular pre/post-trigger capture of one sample stream into debug RAM port 2.
// Define CURRCTRL_DBG_TRIG_EDGE_EN for rising-edge trigger qualification.
module currctrl_debug_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trig_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] plen;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   post;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   post_init;
  logic              trig_q;
  logic              wr_en;
  logic              start_cap;
  logic              capturing;

  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;
  assign cnt_inc        = cnt + 1'b1;
  assign post_init      = LAST - {1'b0, plen};

`ifdef CURRCTRL_DBG_TRIG_EDGE_EN
  logic trig_prev;

  assign trig_q = trig_in & ~trig_prev;

  // Last trigger level seen on a valid sample; starts high so a level
  // already asserted at arm does not count as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_prev <= 1'b1;
    end else if (start_cap) begin
      trig_prev <= 1'b1;
    end else if (capturing && sample_valid) begin
      trig_prev <= trig_in;
    end
  end
`else
  assign trig_q = trig_in;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state: abort dominates, arm only honoured when not capturing
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (arm) state_nx = (pretrig_len == '0) ? S_ARMED : S_PRE;
        end
        S_PRE: begin
          if (sample_valid && cnt_inc == {1'b0, plen}) state_nx = S_ARMED;
        end
        S_ARMED: begin
          if (sample_valid && trig_q)
            state_nx = (post_init == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (sample_valid && post == 1) state_nx = S_DONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Status and write-enable decode
  always_comb begin
    capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    busy      = capturing;
    done      = (state == S_DONE);
    start_cap = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
    wr_en     = capturing && sample_valid && !abort;
  end

  // Write pointer, counters, trigger bookkeeping and registered RAM port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      plen           <= '0;
      cnt            <= '0;
      post           <= '0;
      trig_addr      <= '0;
      start_addr     <= '0;
      ram_address    <= '0;
      ram_writedata  <= '0;
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
    end else begin
      ram_write      <= wr_en;
      ram_chipselect <= wr_en;
      if (wr_en) begin
        ram_address   <= wr_ptr;
        ram_writedata <= sample_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (start_cap) begin
        wr_ptr <= '0;
        plen   <= pretrig_len;
        cnt    <= '0;
      end
      if (wr_en && state == S_PRE) begin
        cnt <= cnt_inc;
      end
      if (wr_en && state == S_ARMED && trig_q) begin
        trig_addr  <= wr_ptr;
        start_addr <= wr_ptr - plen;
        post       <= post_init;
      end
      if (wr_en && state == S_POST) begin
        post <= post - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_currctrl_debug_capture_ctrl.sv
// Bench for currctrl_debug_capture_ctrl: scoreboarded RAM writes,
// table-driven arm/abort sequence and directed capture scenarios.
module tb_currctrl_debug_capture_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pretrig_len;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          trig_in;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_writedata;
  logic [3:0]    ram_byteenable;
  logic          ram_chipselect;
  logic          ram_write;
  logic          ram_clken;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  currctrl_debug_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .abort          (abort),
    .pretrig_len    (pretrig_len),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .trig_in        (trig_in),
    .ram_address    (ram_address),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .busy           (busy),
    .done           (done),
    .trig_addr      (trig_addr),
    .start_addr     (start_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          arm;
    logic          abort;
    logic          valid;
    logic          trig;
    logic [DW-1:0] data;
    logic          wr;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
  } vec_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic ab, input logic v,
                      input logic t, input logic [DW-1:0] d);
    arm          = a;
    abort        = ab;
    sample_valid = v;
    trig_in      = t;
    sample_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input int data);
    exp_t e;
    e.addr = AW'(addr);
    e.data = DW'(data);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    step(L, L, L, L, '0);
    chk({"drain_", name}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard: every RAM write must match the next expected write
  always @(negedge clk) begin
    if (reset_n && ram_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr %0d data %0h, none expected",
                 ram_address, ram_writedata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ram_address !== e.addr || ram_writedata !== e.data ||
            ram_chipselect !== 1'b1) begin
          errors++;
          $display("FAIL wr_cmp: addr %0d data %0h cs %0b, expected addr %0d data %0h cs 1",
                   ram_address, ram_writedata, ram_chipselect, e.addr, e.data);
        end
      end
    end
  end

  function automatic vec_t mv(input logic a, input logic ab, input logic v,
                              input logic t, input logic [DW-1:0] d,
                              input logic w, input logic [AW-1:0] ad,
                              input logic b, input logic dn);
    vec_t r;
    r.arm   = a;
    r.abort = ab;
    r.valid = v;
    r.trig  = t;
    r.data  = d;
    r.wr    = w;
    r.addr  = ad;
    r.busy  = b;
    r.done  = dn;
    return r;
  endfunction

  vec_t tbl [11];
  int   exp_trig;

  initial begin
    tbl[0]  = mv(H, L, L, L, 32'h0,  L, 9'd0, H, L);
    tbl[1]  = mv(L, L, H, L, 32'hA0, H, 9'd0, H, L);
    tbl[2]  = mv(L, L, H, L, 32'hA1, H, 9'd1, H, L);
    tbl[3]  = mv(L, L, H, H, 32'hA2, H, 9'd2, H, L);
    tbl[4]  = mv(L, L, H, L, 32'hA3, H, 9'd3, H, L);
    tbl[5]  = mv(H, L, H, L, 32'hA4, H, 9'd4, H, L);
    tbl[6]  = mv(L, L, L, L, 32'h0,  L, 9'd0, H, L);
    tbl[7]  = mv(L, L, H, L, 32'hA5, H, 9'd5, H, L);
    tbl[8]  = mv(H, H, H, L, 32'hA6, L, 9'd0, L, L);
    tbl[9]  = mv(L, L, L, L, 32'h0,  L, 9'd0, L, L);
    tbl[10] = mv(L, L, H, H, 32'hA7, L, 9'd0, L, L);

    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    arm          = 1'b0;
    abort        = 1'b0;
    pretrig_len  = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    trig_in      = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    #1;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_write", 32'(ram_write), 32'd0);
    chk("rst_cs", 32'(ram_chipselect), 32'd0);
    chk("rst_addr", 32'(ram_address), 32'd0);
    chk("rst_wdata", ram_writedata, 32'd0);
    chk("rst_trig_addr", 32'(trig_addr), 32'd0);
    chk("rst_start_addr", 32'(start_addr), 32'd0);
    chk("byteenable", 32'(ram_byteenable), 32'hF);
    chk("clken", 32'(ram_clken), 32'd1);

`ifndef CURRCTRL_DBG_TRIG_EDGE_EN
    // plen=0, trigger held high: full 512-word capture from address 0
    pretrig_len = 9'd0;
    step(H, L, L, H, '0);
    chk("a_busy_after_arm", 32'(busy), 32'd1);
    for (int i = 0; i < 512; i++) begin
      push(i, i);
      step(L, L, H, H, DW'(i));
      if (i == 510) chk("a_done_early", 32'(done), 32'd0);
    end
    chk("a_done", 32'(done), 32'd1);
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_last_write", 32'(ram_write), 32'd1);
    chk("a_trig_addr", 32'(trig_addr), 32'd0);
    chk("a_start_addr", 32'(start_addr), 32'd0);
    drain("a");
`endif

    // plen=100, trigger on sample 700, stray trigger in PRE ignored
    pretrig_len = 9'd100;
    step(H, L, L, L, '0);
    chk("b_done_cleared", 32'(done), 32'd0);
    chk("b_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 1112; i++) begin
      if (i % 97 == 3) step(L, L, L, L, '0);
      push(i % 512, i);
      step(L, L, H, (i == 700) || (i == 50), DW'(i));
    end
    chk("b_done", 32'(done), 32'd1);
    chk("b_trig_addr", 32'(trig_addr), 32'd188);
    chk("b_start_addr", 32'(start_addr), 32'd88);
    chk("b_last_addr", 32'(ram_address), 32'd87);
    drain("b");

    // plen=511, trigger on first ARMED sample: no POST phase
    pretrig_len = 9'd511;
    step(H, L, L, L, '0);
    for (int i = 0; i < 512; i++) begin
      push(i, 32'h1000 + i);
      step(L, L, H, i == 511, DW'(32'h1000 + i));
      if (i == 510) chk("c_busy_before_trig", 32'(busy), 32'd1);
    end
    chk("c_done", 32'(done), 32'd1);
    chk("c_trig_addr", 32'(trig_addr), 32'd511);
    chk("c_start_addr", 32'(start_addr), 32'd0);
    drain("c");
    step(L, H, L, L, '0);
    chk("c_abort_clears_done", 32'(done), 32'd0);

    // abort in the 40th ARMED cycle, then re-arm restarts at address 0
    pretrig_len = 9'd10;
    step(H, L, L, L, '0);
    for (int i = 0; i < 49; i++) begin
      push(i, 32'h2000 + i);
      step(L, L, H, L, DW'(32'h2000 + i));
    end
    step(L, H, H, H, 32'hDEAD);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_done", 32'(done), 32'd0);
    chk("d_no_write", 32'(ram_write), 32'd0);
    drain("d");
    pretrig_len = 9'd4;
    step(H, L, L, L, '0);
    for (int i = 0; i < 4; i++) begin
      push(i, 32'h3000 + i);
      step(L, L, H, L, DW'(32'h3000 + i));
    end
    step(L, H, L, L, '0);
    drain("d2");

    // arm during POST ignored; arm+abort together aborts
    pretrig_len = 9'd2;
    for (int k = 0; k < 11; k++) begin
      if (tbl[k].wr) push(int'(tbl[k].addr), int'(tbl[k].data));
      step(tbl[k].arm, tbl[k].abort, tbl[k].valid, tbl[k].trig, tbl[k].data);
      chk($sformatf("e_busy_%0d", k), 32'(busy), 32'(tbl[k].busy));
      chk($sformatf("e_done_%0d", k), 32'(done), 32'(tbl[k].done));
      chk($sformatf("e_write_%0d", k), 32'(ram_write), 32'(tbl[k].wr));
    end
    chk("e_trig_addr", 32'(trig_addr), 32'd2);
    drain("e");

    // trigger high at arm, low at sample 5, high again at sample 9
`ifdef CURRCTRL_DBG_TRIG_EDGE_EN
    exp_trig = 9;
`else
    exp_trig = 2;
`endif
    pretrig_len = 9'd2;
    step(H, L, L, H, '0);
    for (int i = 0; i < 12; i++) begin
      push(i, 32'h4000 + i);
      step(L, L, H, !(i >= 5 && i < 9), DW'(32'h4000 + i));
    end
    chk("f_trig_addr", 32'(trig_addr), 32'(exp_trig));
    step(L, H, L, L, '0);
    drain("f");

    // asynchronous reset in the middle of a capture
    pretrig_len = 9'd0;
    step(H, L, L, L, '0);
    for (int i = 0; i < 5; i++) begin
      push(i, 32'h5000 + i);
      step(L, L, H, L, DW'(32'h5000 + i));
    end
    #6;
    reset_n      = 1'b0;
    sample_valid = 1'b1;
    #1;
    chk("g_busy_async", 32'(busy), 32'd0);
    chk("g_write_async", 32'(ram_write), 32'd0);
    chk("g_addr_async", 32'(ram_address), 32'd0);
    @(posedge clk);
    #1;
    chk("g_write_held", 32'(ram_write), 32'd0);
    #3 reset_n = 1'b1;
    step(L, L, H, L, 32'h5555);
    chk("g_idle_no_write", 32'(ram_write), 32'd0);
    chk("g_idle_busy", 32'(busy), 32'd0);
    drain("g");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
